result_byte_serializer: RTL and testbench

Downstream stage of the multiplier processing unit. It captures the unit's strobed 32-bit results (no backpressure upstream) into a small FIFO and re-emits each one as 4 bytes, LSB first, on a valid/ready byte stream. The byte stream feeds the test design's UART/output path. Results that arrive while the buffer is full are dropped and flagged with a sticky overflow bit.

---
 rtl/result_byte_serializer_pkg.sv | 13 +
 rtl/sync_word_fifo.sv | 59 +++++
 rtl/result_byte_serializer.sv | 105 ++++++++++
 tb/tb_result_byte_serializer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/result_byte_serializer_pkg.sv
// Shared types and constants for the result byte serializer.
// Holds the word width in bytes and the serializer state encoding.
package result_byte_serializer_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with show-ahead head output; 2**LOG2 entries.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_word_fifo #(
    parameter int WIDTH = 32,
    parameter int LOG2  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [LOG2:0]    o_level
);

    logic [WIDTH-1:0] r_mem [2**LOG2];
    logic [LOG2-1:0]  r_wr_ptr;
    logic [LOG2-1:0]  r_rd_ptr;
    logic [LOG2:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Count never exceeds 2**LOG2, so its MSB alone marks full.
    assign o_full    = r_count[LOG2];
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/result_byte_serializer.sv
// Buffers strobed 32-bit results and streams them as bytes, LSB first, on valid/ready.
// First byte appears two cycles after the strobe; words arriving while full are dropped into OVF.
module result_byte_serializer
    import result_byte_serializer_pkg::*;
#(
    parameter int FIFO_LOG2 = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               I_STB,
    input  logic [31:0]        I_DAT,
    output logic               O_VLD,
    output logic [7:0]         O_DAT,
    input  logic               O_RDY,
    output logic               OVF,
    input  logic               CLR_OVF,
    output logic [FIFO_LOG2:0] LEVEL
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    ser_state_t       r_state;
    ser_state_t       w_next_state;
    logic [31:0]      r_word;
    logic [IDX_W-1:0] r_idx;
    logic             r_ovf;
    logic [31:0]      w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_last;
    logic             w_xfer;
    logic             w_pop;

    sync_word_fifo #(
        .WIDTH (32),
        .LOG2  (FIFO_LOG2)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (I_STB),
        .i_pop   (w_pop),
        .i_din   (I_DAT),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (LEVEL)
    );

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!w_empty) w_next_state = SEND;
            SEND:    if (O_RDY && w_last && w_empty) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Refill straight from the FIFO on the last byte so back-to-back words have no bubble.
    always_comb begin
        O_VLD  = (r_state == SEND);
        w_xfer = (r_state == SEND) && O_RDY;
        w_pop  = 1'b0;
        case (r_state)
            IDLE:    w_pop = !w_empty;
            SEND:    w_pop = O_RDY && w_last && !w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (w_pop) begin
            r_word <= w_head;
            r_idx  <= '0;
        end else if (w_xfer) begin
            r_idx  <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else if (I_STB && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (CLR_OVF) begin
            r_ovf <= 1'b0;
        end
    end

    assign OVF   = r_ovf;
    assign O_DAT = r_word[{r_idx, 3'b000} +: 8];

endmodule

// File: tb/tb_result_byte_serializer.sv
// Directed bench for result_byte_serializer: vector table plus hand-built corner sequences.
module tb_result_byte_serializer;

    localparam int FIFO_LOG2 = 4;

    logic               CLK;
    logic               RST;
    logic               I_STB;
    logic [31:0]        I_DAT;
    logic               O_VLD;
    logic [7:0]         O_DAT;
    logic               O_RDY;
    logic               OVF;
    logic               CLR_OVF;
    logic [FIFO_LOG2:0] LEVEL;

    result_byte_serializer #(.FIFO_LOG2(FIFO_LOG2)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .I_STB   (I_STB),
        .I_DAT   (I_DAT),
        .O_VLD   (O_VLD),
        .O_DAT   (O_DAT),
        .O_RDY   (O_RDY),
        .OVF     (OVF),
        .CLR_OVF (CLR_OVF),
        .LEVEL   (LEVEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        stb;
        logic [31:0] dat;
        logic        rdy;
        logic        exp_vld;
        logic [7:0]  exp_dat;
        int          exp_lvl;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic stb, input logic [31:0] dat, input logic rdy,
                       input logic vld, input logic [7:0] d, input int lvl);
        vec_t v;
        v.stb = stb; v.dat = dat; v.rdy = rdy;
        v.exp_vld = vld; v.exp_dat = d; v.exp_lvl = lvl;
        vq.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bq[$];
        logic [7:0] exp_b;
        int         n;

        // Each row: inputs for one cycle, then the outputs seen after that edge.
        add(1, 32'h11223344, 1, 0, 8'h00, 1);
        add(0, 32'h0,        1, 1, 8'h44, 0);
        add(0, 32'h0,        1, 1, 8'h33, 0);
        add(0, 32'h0,        1, 1, 8'h22, 0);
        add(0, 32'h0,        1, 1, 8'h11, 0);
        add(0, 32'h0,        1, 0, 8'h00, 0);
        add(1, 32'h11223344, 0, 0, 8'h00, 1);
        add(0, 32'h0,        0, 1, 8'h44, 0);
        add(0, 32'h0,        1, 1, 8'h33, 0);
        add(0, 32'h0,        0, 1, 8'h33, 0);
        add(0, 32'h0,        0, 1, 8'h33, 0);
        add(0, 32'h0,        1, 1, 8'h22, 0);
        add(0, 32'h0,        0, 1, 8'h22, 0);
        add(0, 32'h0,        1, 1, 8'h11, 0);
        add(0, 32'h0,        1, 0, 8'h00, 0);
        add(1, 32'hA0A1A2A3, 1, 0, 8'h00, 1);
        add(1, 32'hB0B1B2B3, 1, 1, 8'hA3, 1);
        add(1, 32'hC0C1C2C3, 1, 1, 8'hA2, 2);
        add(0, 32'h0,        1, 1, 8'hA1, 2);
        add(0, 32'h0,        1, 1, 8'hA0, 2);
        add(0, 32'h0,        1, 1, 8'hB3, 1);
        add(0, 32'h0,        1, 1, 8'hB2, 1);
        add(0, 32'h0,        1, 1, 8'hB1, 1);
        add(0, 32'h0,        1, 1, 8'hB0, 1);
        add(0, 32'h0,        1, 1, 8'hC3, 0);
        add(0, 32'h0,        1, 1, 8'hC2, 0);
        add(0, 32'h0,        1, 1, 8'hC1, 0);
        add(0, 32'h0,        1, 1, 8'hC0, 0);
        add(0, 32'h0,        1, 0, 8'h00, 0);

        RST = 1'b1; I_STB = 1'b0; I_DAT = '0; O_RDY = 1'b0; CLR_OVF = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_vld", O_VLD, 0);
        chk("rst_dat", O_DAT, 0);
        chk("rst_lvl", LEVEL, 0);
        chk("rst_ovf", OVF, 0);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < vq.size(); i++) begin
            I_STB = vq[i].stb; I_DAT = vq[i].dat; O_RDY = vq[i].rdy;
            @(negedge CLK);
            chk($sformatf("row%0d_vld", i), O_VLD, vq[i].exp_vld);
            if (vq[i].exp_vld) chk($sformatf("row%0d_dat", i), O_DAT, vq[i].exp_dat);
            chk($sformatf("row%0d_lvl", i), LEVEL, vq[i].exp_lvl);
            chk($sformatf("row%0d_ovf", i), OVF, 0);
        end
        I_STB = 1'b0;

        // Overflow: 18 strobes with no drain, word 17 must be lost.
        O_RDY = 1'b0;
        for (int k = 0; k < 18; k++) begin
            I_STB = 1'b1; I_DAT = 32'(k);
            @(negedge CLK);
        end
        I_STB = 1'b0;
        chk("ovf_lvl", LEVEL, 16);
        chk("ovf_set", OVF, 1);
        chk("ovf_vld", O_VLD, 1);
        for (int w = 0; w < 17; w++) begin
            bq.push_back(8'(w));
            bq.push_back(8'h00); bq.push_back(8'h00); bq.push_back(8'h00);
        end
        O_RDY = 1'b1;
        n = 0;
        for (int t = 0; t < 200 && bq.size() > 0; t++) begin
            if (O_VLD) begin
                exp_b = bq.pop_front();
                chk($sformatf("drain_byte%0d", n), O_DAT, exp_b);
                n++;
            end
            @(negedge CLK);
        end
        chk("drain_count", n, 68);
        chk("drain_vld", O_VLD, 0);
        chk("drain_lvl", LEVEL, 0);
        chk("ovf_sticky", OVF, 1);
        CLR_OVF = 1'b1;
        @(negedge CLK);
        CLR_OVF = 1'b0;
        chk("ovf_clr", OVF, 0);

        // Full FIFO, strobe coinciding with the last-byte pop.
        O_RDY = 1'b0;
        for (int k = 0; k < 17; k++) begin
            I_STB = 1'b1; I_DAT = 32'h5A3C0000 | 32'(k);
            @(negedge CLK);
        end
        I_STB = 1'b0;
        chk("full_lvl", LEVEL, 16);
        chk("full_b0", O_DAT, 8'h00);
        O_RDY = 1'b1;
        repeat (3) @(negedge CLK);
        chk("full_b3", O_DAT, 8'h5A);
        chk("full_lvl_hold", LEVEL, 16);
        I_STB = 1'b1; I_DAT = 32'h5A3C00FF;
        @(negedge CLK);
        I_STB = 1'b0; O_RDY = 1'b0;
        chk("swap_lvl", LEVEL, 16);
        chk("swap_ovf", OVF, 0);
        chk("swap_vld", O_VLD, 1);
        chk("swap_next", O_DAT, 8'h01);

        // Drop one word, move two bytes in, then reset mid-word.
        I_STB = 1'b1; I_DAT = 32'hFFFFFFFF;
        @(negedge CLK);
        I_STB = 1'b0;
        chk("drop_ovf", OVF, 1);
        chk("drop_lvl", LEVEL, 16);
        O_RDY = 1'b1;
        repeat (2) @(negedge CLK);
        O_RDY = 1'b0;
        chk("mid_b2", O_DAT, 8'h3C);
        #2 RST = 1'b1;
        #1;
        chk("arst_vld", O_VLD, 0);
        chk("arst_lvl", LEVEL, 0);
        chk("arst_ovf", OVF, 0);
        chk("arst_dat", O_DAT, 0);
        @(negedge CLK);
        RST = 1'b0;
        O_RDY = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge CLK);
            chk($sformatf("post_rst_vld%0d", t), O_VLD, 0);
        end
        chk("post_rst_lvl", LEVEL, 0);

        I_STB = 1'b1; I_DAT = 32'hDEADBEEF;
        @(negedge CLK);
        I_STB = 1'b0;
        chk("resume_c1", O_VLD, 0);
        @(negedge CLK);
        chk("resume_c2", O_VLD, 1);
        chk("resume_b0", O_DAT, 8'hEF);
        @(negedge CLK);
        chk("resume_b1", O_DAT, 8'hBE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
